// File: rtl/rx_if.sv
// Bus-side signal bundle for the SPART receiver: baud enable, serial line,
// read strobe and the registered receive data/status returned to the bus.
interface rx_if;
  logic       en;
  logic       RxD;
  logic       clr_rda;
  logic [7:0] data;
  logic       rda;
  logic       ferr;
  logic       ovr;

  // Bus/stimulus side: drives the line, baud enable and read strobe.
  modport master (
    output en,
    output RxD,
    output clr_rda,
    input  data,
    input  rda,
    input  ferr,
    input  ovr
  );

  // Receiver side.
  modport slave (
    input  en,
    input  RxD,
    input  clr_rda,
    output data,
    output rda,
    output ferr,
    output ovr
  );
endinterface

// File: rtl/rx.sv
// 8N1 UART receiver using the 16x oversampling baud enable shared with tx.
// Holds the last byte with data-available, framing-error and overrun flags.
module rx (
  input  logic clk,
  input  logic rst,
  rx_if.slave  bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic       sync_q;
  logic       rxs_q;
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] nbit_q, nbit_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic       rda_q, rda_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;
  logic       load;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      sync_q <= bus.RxD;
      rxs_q  <= sync_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nbit_d  = nbit_q;
    shreg_d = shreg_q;
    load    = 1'b0;
    if (bus.en) begin
      case (state_q)
        StIdle: begin
          if (!rxs_q) begin
            state_d = StStart;
            cnt_d   = 4'd0;
          end
        end
        StStart: begin
          cnt_d = cnt_q + 4'd1;
          // Mid start bit: a high line here means the low pulse was a glitch.
          if (cnt_q == 4'd7) begin
            if (!rxs_q) begin
              state_d = StData;
              cnt_d   = 4'd0;
              nbit_d  = 4'd0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StData: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            shreg_d = {rxs_q, shreg_q[7:1]};
            nbit_d  = nbit_q + 4'd1;
            if (nbit_q == 4'd7) begin
              state_d = StStop;
              cnt_d   = 4'd0;
            end
          end
        end
        StStop: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            load    = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A load always lands, even with clr_rda in the same cycle; the clear then
  // only suppresses the overrun.
  always_comb begin
    data_d = data_q;
    rda_d  = rda_q;
    ferr_d = ferr_q;
    ovr_d  = ovr_q;
    if (load) begin
      data_d = shreg_q;
      ferr_d = ~rxs_q;
      rda_d  = 1'b1;
      if (rda_q && !bus.clr_rda) begin
        ovr_d = 1'b1;
      end else if (bus.clr_rda) begin
        ovr_d = 1'b0;
      end
    end else if (bus.clr_rda) begin
      rda_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      nbit_q  <= 4'd0;
      shreg_q <= 8'h00;
      data_q  <= 8'h00;
      rda_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nbit_q  <= nbit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      rda_q   <= rda_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.data = data_q;
  assign bus.rda  = rda_q;
  assign bus.ferr = ferr_q;
  assign bus.ovr  = ovr_q;

endmodule

// File: tb/tb_rx.sv
// Directed bench for rx: frames are driven one en tick (6 clocks) at a time,
// 16 ticks per bit, so the stop-bit sample falls on tick 8 of bit 9.
module tb_rx;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  rx_if bus ();

  rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "timeout");
  end

  // One en tick: 5 idle clocks then a clock with en high; clr/rst ride on the en clock.
  task automatic tick(input logic clr, input logic rp);
    repeat (5) @(posedge clk);
    #1;
    bus.en      = 1'b1;
    bus.clr_rda = clr;
    rst         = rp;
    @(posedge clk);
    #1;
    bus.en      = 1'b0;
    bus.clr_rda = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.RxD = 1'b1;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  // Sends the first nbits of {stop, b, start}; clr_load pulses clr_rda on the stop sample.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic clr_load,
                            input int nbits);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.RxD = f[i];
      for (int t = 0; t < 16; t++) tick((i == 9 && t == 8) ? clr_load : 1'b0, 1'b0);
    end
  endtask

  task automatic clr_pulse();
    bus.clr_rda = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_rda = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.data); end
    checks++; if (bus.rda !== 1'b0) begin errors++; $display("FAIL reset_rda: got %b want 0", bus.rda); end
    checks++; if (bus.ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", bus.ferr); end
    checks++; if (bus.ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", bus.ovr); end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_normal();
    send_frame(8'hE3, 1'b1, 1'b0, 9);
    bus.RxD = 1'b1;
    repeat (8) tick(1'b0, 1'b0);
    checks++; if (bus.rda !== 1'b0) begin errors++; $display("FAIL normal_early_rda: got %b want 0", bus.rda); end
    tick(1'b0, 1'b0);
    checks++; if (bus.rda !== 1'b1) begin errors++; $display("FAIL normal_rda: got %b want 1", bus.rda); end
    checks++; if (bus.data !== 8'hE3) begin errors++; $display("FAIL normal_data: got %h want e3", bus.data); end
    checks++; if (bus.ferr !== 1'b0) begin errors++; $display("FAIL normal_ferr: got %b want 0", bus.ferr); end
    checks++; if (bus.ovr !== 1'b0) begin errors++; $display("FAIL normal_ovr: got %b want 0", bus.ovr); end
    repeat (7) tick(1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_read();
    clr_pulse();
    checks++; if (bus.rda !== 1'b0) begin errors++; $display("FAIL read_clr_rda: got %b want 0", bus.rda); end
    checks++; if (bus.data !== 8'hE3) begin errors++; $display("FAIL read_keep_data: got %h want e3", bus.data); end
    send_frame(8'h5A, 1'b1, 1'b0, 10);
    idle(2);
    checks++; if (bus.rda !== 1'b1) begin errors++; $display("FAIL read_5a_rda: got %b want 1", bus.rda); end
    checks++; if (bus.data !== 8'h5A) begin errors++; $display("FAIL read_5a_data: got %h want 5a", bus.data); end
    clr_pulse();
  endtask

  task automatic test_glitch();
    bus.RxD = 1'b0;
    repeat (3) tick(1'b0, 1'b0);
    idle(13);
    checks++; if (bus.rda !== 1'b0) begin errors++; $display("FAIL glitch_rda: got %b want 0", bus.rda); end
    send_frame(8'hA5, 1'b1, 1'b0, 10);
    idle(2);
    checks++; if (bus.rda !== 1'b1) begin errors++; $display("FAIL glitch_a5_rda: got %b want 1", bus.rda); end
    checks++; if (bus.data !== 8'hA5) begin errors++; $display("FAIL glitch_a5_data: got %h want a5", bus.data); end
    checks++; if (bus.ferr !== 1'b0) begin errors++; $display("FAIL glitch_a5_ferr: got %b want 0", bus.ferr); end
    clr_pulse();
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, 1'b0, 10);
    idle(4);
    checks++; if (bus.rda !== 1'b1) begin errors++; $display("FAIL ferr_rda: got %b want 1", bus.rda); end
    checks++; if (bus.data !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h want 3c", bus.data); end
    checks++; if (bus.ferr !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", bus.ferr); end
    clr_pulse();
    send_frame(8'h81, 1'b1, 1'b0, 10);
    idle(2);
    checks++; if (bus.data !== 8'h81) begin errors++; $display("FAIL ferr_81_data: got %h want 81", bus.data); end
    checks++; if (bus.ferr !== 1'b0) begin errors++; $display("FAIL ferr_81_ferr: got %b want 0", bus.ferr); end
    checks++; if (bus.ovr !== 1'b0) begin errors++; $display("FAIL ferr_81_ovr: got %b want 0", bus.ovr); end
    clr_pulse();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 1'b0, 10);
    send_frame(8'h22, 1'b1, 1'b0, 10);
    idle(2);
    checks++; if (bus.data !== 8'h22) begin errors++; $display("FAIL ovr_data: got %h want 22", bus.data); end
    checks++; if (bus.ovr !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", bus.ovr); end
    clr_pulse();
    checks++; if (bus.ovr !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b want 0", bus.ovr); end
    checks++; if (bus.rda !== 1'b0) begin errors++; $display("FAIL ovr_clr_rda: got %b want 0", bus.rda); end
    send_frame(8'h33, 1'b1, 1'b0, 10);
    send_frame(8'h44, 1'b1, 1'b0, 10);
    checks++; if (bus.ovr !== 1'b1) begin errors++; $display("FAIL ovr_set2: got %b want 1", bus.ovr); end
    send_frame(8'h55, 1'b1, 1'b1, 10);
    idle(2);
    checks++; if (bus.rda !== 1'b1) begin errors++; $display("FAIL ovr_sim_rda: got %b want 1", bus.rda); end
    checks++; if (bus.ovr !== 1'b0) begin errors++; $display("FAIL ovr_sim_ovr: got %b want 0", bus.ovr); end
    checks++; if (bus.data !== 8'h55) begin errors++; $display("FAIL ovr_sim_data: got %h want 55", bus.data); end
  endtask

  task automatic test_reset_midframe();
    // rda is still set, so this bad-stop frame also raises ovr.
    send_frame(8'h3C, 1'b0, 1'b0, 10);
    idle(12);
    checks++; if (bus.ferr !== 1'b1) begin errors++; $display("FAIL mid_pre_ferr: got %b want 1", bus.ferr); end
    checks++; if (bus.ovr !== 1'b1) begin errors++; $display("FAIL mid_pre_ovr: got %b want 1", bus.ovr); end
    // 8'hF5: start + d0..d3, then d4..d7 and stop are all high.
    send_frame(8'hF5, 1'b1, 1'b0, 5);
    bus.RxD = 1'b1;
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h want 00", bus.data); end
    checks++; if (bus.rda !== 1'b0) begin errors++; $display("FAIL mid_rst_rda: got %b want 0", bus.rda); end
    checks++; if (bus.ferr !== 1'b0) begin errors++; $display("FAIL mid_rst_ferr: got %b want 0", bus.ferr); end
    checks++; if (bus.ovr !== 1'b0) begin errors++; $display("FAIL mid_rst_ovr: got %b want 0", bus.ovr); end
    idle(12 + 16 * 4 + 8);
    checks++; if (bus.rda !== 1'b0) begin errors++; $display("FAIL mid_abort_rda: got %b want 0", bus.rda); end
    send_frame(8'h77, 1'b1, 1'b0, 10);
    idle(2);
    checks++; if (bus.rda !== 1'b1) begin errors++; $display("FAIL mid_77_rda: got %b want 1", bus.rda); end
    checks++; if (bus.data !== 8'h77) begin errors++; $display("FAIL mid_77_data: got %h want 77", bus.data); end
    checks++; if (bus.ferr !== 1'b0) begin errors++; $display("FAIL mid_77_ferr: got %b want 0", bus.ferr); end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.RxD     = 1'b1;
    bus.clr_rda = 1'b0;
    test_reset();
    test_normal();
    test_read();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
